if_stage: RTL

//  Instruction-fetch stage of the 5-stage pipelined MIPS core. Holds the PC register and

---
 rtl/if_stage.sv | 63 ++++++
 1 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection (adder / branch / jump),
// IF/ID pipeline register with stall and flush, plus fetch and stall counters.
module if_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
   input  logic [31:0] pc_plus4_in,
   input  logic [31:0] instr_in,
   output logic [31:0] pc_out,
   output logic [31:0] ifid_pc4,
   output logic [31:0] ifid_instr,
   output logic        ifid_valid,
   output logic        misalign,
   output logic [31:0] fetch_cnt,
   output logic [31:0] stall_cnt
);

   logic        redirect;
   logic [31:0] redirect_target;

   // A jump outranks a simultaneous taken branch.
   always_comb begin
      redirect        = jump | branch_taken;
      redirect_target = jump ? jump_target : branch_target;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_out     <= RESET_PC;
         ifid_pc4   <= 32'h0;
         ifid_instr <= NOP_INSTR;
         ifid_valid <= 1'b0;
         misalign   <= 1'b0;
         fetch_cnt  <= 32'h0;
         stall_cnt  <= 32'h0;
      end else if (stall) begin
         // Redirects are dropped here; the hazard unit re-presents them afterwards.
         stall_cnt <= stall_cnt + 32'd1;
      end else if (redirect) begin
         pc_out     <= {redirect_target[31:2], 2'b00};
         ifid_pc4   <= 32'h0;
         ifid_instr <= NOP_INSTR;
         ifid_valid <= 1'b0;
         if (redirect_target[1:0] != 2'b00) begin
            misalign <= 1'b1;
         end
      end else begin
         pc_out     <= pc_plus4_in;
         ifid_pc4   <= pc_plus4_in;
         ifid_instr <= instr_in;
         ifid_valid <= 1'b1;
         fetch_cnt  <= fetch_cnt + 32'd1;
      end
   end

endmodule
